rca8: RTL and testbench

RCA8 -- requirements
Module: rca8

---
 rtl/rca8_fac.sv | 21 ++
 rtl/rca8.sv | 74 +++++++
 tb/tb_rca8.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rca8_fac.sv
// -----------------------------------------------------------------------------
// fac -- one-bit full adder cell, the building block of the rca8 ripple chain.
//
// Ports:
//   x, y   : input  operand bits
//   c_in   : input  carry into this bit position
//   z      : output sum bit            (x ^ y ^ c_in)
//   c_out  : output carry to next bit  (majority of x, y, c_in)
// -----------------------------------------------------------------------------
module fac (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic z,
    output logic c_out
);

    assign z     = x ^ y ^ c_in;
    assign c_out = (x & y) | (x & c_in) | (y & c_in);

endmodule

// File: rtl/rca8.sv
// -----------------------------------------------------------------------------
// rca8 -- registered ripple-carry adder.
//
// Computes {c_out, z} = x + y + c_in through a chain of WIDTH full adder
// cells and captures the sum, the unsigned carry out and the two's-complement
// overflow flag together on each rising clk edge (latency 1, one op/cycle).
//
// Ports:
//   clk    : input  clock, all state changes on its rising edge
//   rst    : input  synchronous active-high reset, clears all outputs
//   x, y   : input  [WIDTH-1:0] operands (unsigned or two's complement)
//   c_in   : input  carry into bit 0
//   z      : output [WIDTH-1:0] registered sum
//   c_out  : output registered carry out of the MSB
//   ovr    : output registered two's-complement overflow
// -----------------------------------------------------------------------------
module rca8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic [WIDTH-1:0] z,
    output logic             c_out,
    output logic             ovr
);

    // c[i] is the carry into stage i; c[WIDTH] leaves the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        fac u_fac (
            .x     (x[i]),
            .y     (y[i]),
            .c_in  (c[i]),
            .z     (sum[i]),
            .c_out (c[i+1])
        );
    end

    logic [WIDTH-1:0] z_d,     z_q;
    logic             c_out_d, c_out_q;
    logic             ovr_d,   ovr_q;

    // Reset is folded into the next-state values so all three outputs are
    // always loaded together from the same sampled inputs.
    always_comb begin
        z_d     = sum;
        c_out_d = c[WIDTH];
        // Carry into and out of the sign bit disagree exactly on signed overflow.
        ovr_d   = c[WIDTH] ^ c[WIDTH-1];
        if (rst) begin
            z_d     = '0;
            c_out_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        z_q     <= z_d;
        c_out_q <= c_out_d;
        ovr_q   <= ovr_d;
    end

    assign z     = z_q;
    assign c_out = c_out_q;
    assign ovr   = ovr_q;

endmodule

// File: tb/tb_rca8.sv
// -----------------------------------------------------------------------------
// tb_rca8 -- self-checking bench for rca8 (WIDTH = 8).
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge that captured them. Expected values come from plain integer
// arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_rca8;

    logic       clk;
    logic       rst;
    logic [7:0] x;
    logic [7:0] y;
    logic       c_in;
    logic [7:0] z;
    logic       c_out;
    logic       ovr;

    int checks;
    int errors;

    rca8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .y     (y),
        .c_in  (c_in),
        .z     (z),
        .c_out (c_out),
        .ovr   (ovr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {c_out, z, ovr} for a + b + ci.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci);
        int unsigned s;
        logic [8:0]  s9;
        logic        ov;
        s  = int'(a) + int'(b) + int'(ci);
        s9 = s[8:0];
        ov = (a[7] == b[7]) && (s9[7] != a[7]);
        return {s9[8], s9[7:0], ov};
    endfunction

    // ---------------- driver ----------------
    // Apply one set of inputs and wait until the capturing edge has passed.
    task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic ci);
        @(negedge clk);
        rst  = r;
        x    = a;
        y    = b;
        c_in = ci;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [9:0] obs;
        drive(1'b1, 8'hA5, 8'h3C, 1'b1);
        obs = {c_out, z, ovr};
        checks++;
        if (obs !== 10'h000) begin
            errors++;
            $display("FAIL reset_state: got c_out/z/ovr=%h want %h", obs, 10'h000);
        end
    endtask

    task automatic test_directed();
        logic [7:0] xa [7];
        logic [7:0] ya [7];
        logic       ca [7];
        logic [9:0] want [7];
        logic [9:0] obs;
        xa = '{8'h0F, 8'h7F, 8'h2B, 8'h83, 8'hFF, 8'h7F, 8'h00};
        ya = '{8'h01, 8'h01, 8'h00, 8'hFB, 8'h00, 8'h00, 8'h00};
        ca = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
        // Hand-derived {c_out, z, ovr}.
        want = '{{1'b0, 8'h10, 1'b0}, {1'b0, 8'h80, 1'b1}, {1'b0, 8'h2B, 1'b0},
                 {1'b1, 8'h7E, 1'b1}, {1'b1, 8'h00, 1'b0}, {1'b0, 8'h80, 1'b1},
                 {1'b0, 8'h00, 1'b0}};
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, xa[i], ya[i], ca[i]);
            obs = {c_out, z, ovr};
            checks++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL directed_%0d: x=%h y=%h c_in=%b got %h want %h",
                         i, xa[i], ya[i], ca[i], obs, want[i]);
            end
        end
    endtask

    task automatic test_swap();
        logic [9:0] obs;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        drive(1'b0, 8'h83, 8'h02, 1'b0);
        obs = {c_out, z, ovr};
        checks++;
        if (obs !== {1'b0, 8'h85, 1'b0}) begin
            errors++;
            $display("FAIL swap_fwd: got %h want %h", obs, {1'b0, 8'h85, 1'b0});
        end
        drive(1'b0, 8'h02, 8'h83, 1'b0);
        obs = {c_out, z, ovr};
        checks++;
        if (obs !== {1'b0, 8'h85, 1'b0}) begin
            errors++;
            $display("FAIL swap_rev: got %h want %h", obs, {1'b0, 8'h85, 1'b0});
        end
        for (int i = 0; i < 10; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            ci = 1'($urandom_range(0, 1));
            drive(1'b0, b, a, ci);
            obs = {c_out, z, ovr};
            checks++;
            if (obs !== model(a, b, ci)) begin
                errors++;
                $display("FAIL swap_rand: x=%h y=%h c_in=%b got %h want %h",
                         b, a, ci, obs, model(a, b, ci));
            end
        end
    endtask

    task automatic test_reset_seq();
        logic [9:0] obs;
        drive(1'b1, 8'hFF, 8'hFF, 1'b1);
        obs = {c_out, z, ovr};
        checks++;
        if (obs !== 10'h000) begin
            errors++;
            $display("FAIL reset_override: got %h want %h", obs, 10'h000);
        end
        drive(1'b0, 8'hFF, 8'hFF, 1'b1);
        obs = {c_out, z, ovr};
        checks++;
        if (obs !== {1'b1, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs, {1'b1, 8'hFF, 1'b0});
        end
    endtask

    task automatic test_reset_midstream();
        logic [9:0] obs;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        for (int i = 0; i < 12; i++) begin
            logic r;
            r  = (i >= 4 && i < 7);
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            ci = 1'($urandom_range(0, 1));
            drive(r, a, b, ci);
            obs = {c_out, z, ovr};
            checks++;
            if (r) begin
                if (obs !== 10'h000) begin
                    errors++;
                    $display("FAIL midstream_reset_%0d: got %h want %h", i, obs, 10'h000);
                end
            end else if (obs !== model(a, b, ci)) begin
                errors++;
                $display("FAIL midstream_run_%0d: x=%h y=%h c_in=%b got %h want %h",
                         i, a, b, ci, obs, model(a, b, ci));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [9:0] obs;
        logic [9:0] exp_q[$];
        // New operands every cycle; each result must belong to the previous edge only.
        for (int i = 0; i < 200; i++) begin
            case (i % 4)
                0: begin a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); end
                1: begin a = 8'($urandom_range(120, 135)); b = 8'($urandom_range(0, 15)); end
                2: begin a = 8'($urandom_range(240, 255)); b = 8'($urandom_range(0, 20)); end
                default: begin a = 8'($urandom_range(128, 255)); b = 8'($urandom_range(128, 255)); end
            endcase
            ci = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, ci));
            drive(1'b0, a, b, ci);
            obs = {c_out, z, ovr};
            checks++;
            if (obs !== exp_q[0]) begin
                errors++;
                $display("FAIL back_to_back_%0d: x=%h y=%h c_in=%b got %h want %h",
                         i, a, b, ci, obs, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        x      = '0;
        y      = '0;
        c_in   = 1'b0;
        test_reset();
        test_directed();
        test_swap();
        test_reset_seq();
        test_reset_midstream();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
